// File: rtl/oddrx1f.sv
// One-bit DDR output register: captures a D0/D1 pair on each rising SCLK edge and
// replays it on Q one cycle later (D0 while SCLK is high, D1 while SCLK is low).
module oddrx1f #(
    parameter logic  RST_VAL = 1'b0,
    parameter string GSR     = "ENABLED"
) (
    input  logic SCLK,
    input  logic RST,
    input  logic D0,
    input  logic D1,
    output logic Q
);

    logic [1:0] din;
    logic [1:0] lane_out;
    logic       q1n_reg = 1'b0;

    assign din = {D1, D0};

    // Lane 0 carries the high-phase bit and lane 1 the low-phase bit. Each lane has
    // a capture stage and an output stage, which gives one cycle of latency.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic cap_reg = 1'b0;
        logic out_reg = 1'b0;

        always_ff @(posedge SCLK) begin
            if (!RST) begin
                cap_reg <= RST_VAL;
                out_reg <= RST_VAL;
            end else begin
                cap_reg <= din[gi];
                out_reg <= cap_reg;
            end
        end

        assign lane_out[gi] = out_reg;
    end

    // Retiming the low-phase bit onto the falling edge keeps it stable for the whole
    // low phase. It also carries RST_VAL one half-period after a reset edge.
    always_ff @(negedge SCLK) begin
        q1n_reg <= lane_out[1];
    end

    // GSR is kept only so that existing instantiations still elaborate.
    if (GSR == "DISABLED") begin : g_gsr_disabled
    end else begin : g_gsr_enabled
    end

    assign Q = SCLK ? lane_out[0] : q1n_reg;

endmodule

// File: tb/tb_oddrx1f.sv
// Scoreboard bench for oddrx1f. Two instances are checked side by side:
// u_dut0 uses RST_VAL=0 and u_dut1 uses RST_VAL=1.
module tb_oddrx1f;

    logic SCLK = 1'b0;
    logic RST  = 1'b0;
    logic D0   = 1'b0;
    logic D1   = 1'b0;
    logic q_rv0;
    logic q_rv1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic rst_n;
        logic d0;
        logic d1;
    } ent_t;

    ent_t exp_q[$];

    oddrx1f #(.RST_VAL(1'b0), .GSR("ENABLED")) u_dut0 (
        .SCLK(SCLK), .RST(RST), .D0(D0), .D1(D1), .Q(q_rv0)
    );

    oddrx1f #(.RST_VAL(1'b1), .GSR("DISABLED")) u_dut1 (
        .SCLK(SCLK), .RST(RST), .D0(D0), .D1(D1), .Q(q_rv1)
    );

    always #5 SCLK = ~SCLK;

    // Each entry is {rst_n, d0, d1, glitch}. When glitch=1, every input is inverted
    // for a short time between two rising edges and then restored.
    localparam int N = 25;
    logic [3:0] stim [0:N-1] = '{
        4'b0110, 4'b0110, 4'b0110,                     // reset held with D=1,1
        4'b1110, 4'b1110,                              // release: 1s appear one cycle later
        4'b1100, 4'b1100, 4'b1100, 4'b1100,            // 1/0 toggle stream
        4'b1110, 4'b1000, 4'b1100, 4'b1010,            // (1,1),(0,0),(1,0),(0,1)
        4'b1100, 4'b1100, 4'b0100,                     // one reset edge mid-stream
        4'b1100, 4'b1100, 4'b1100,
        4'b1001, 4'b1001,                              // pulses between rising edges
        4'b1x00, 4'b1010, 4'b1000, 4'b1000             // X on D0 for a single capture
    };

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic rst_edge_n, input logic ent_rst_n,
                                     input logic rv, input logic d);
        // A reset at this edge or at the capture edge replaces the data with rv.
        return (!rst_edge_n || !ent_rst_n) ? rv : d;
    endfunction

    initial begin
        ent_t e;
        logic rst_s;
        logic d0_s;
        logic d1_s;

        // Both instances power up at 0, including the RST_VAL=1 instance.
        exp_q.push_back('{rst_n: 1'b1, d0: 1'b0, d1: 1'b0});
        #1;
        chk("powerup_rv0", q_rv0, 1'b0);
        chk("powerup_rv1", q_rv1, 1'b0);

        for (int i = 0; i < N; i++) begin
            RST = stim[i][3];
            D0  = stim[i][2];
            D1  = stim[i][1];
            @(posedge SCLK);
            rst_s = RST;
            d0_s  = D0;
            d1_s  = D1;
            e = exp_q.pop_front();
            exp_q.push_back('{rst_n: rst_s, d0: d0_s, d1: d1_s});

            #2;
            chk($sformatf("hi_rv0[%0d]", i), q_rv0, exp_bit(rst_s, e.rst_n, 1'b0, e.d0));
            chk($sformatf("hi_rv1[%0d]", i), q_rv1, exp_bit(rst_s, e.rst_n, 1'b1, e.d0));

            if (stim[i][0]) begin
                #1;
                RST = ~RST;
                D0  = ~D0;
                D1  = ~D1;
                #1;
                RST = stim[i][3];
                D0  = stim[i][2];
                D1  = stim[i][1];
            end

            @(negedge SCLK);
            #2;
            chk($sformatf("lo_rv0[%0d]", i), q_rv0, exp_bit(rst_s, e.rst_n, 1'b0, e.d1));
            chk($sformatf("lo_rv1[%0d]", i), q_rv1, exp_bit(rst_s, e.rst_n, 1'b1, e.d1));

            $display("step %0d: rst=%b d0=%b d1=%b -> expected hi=%b lo=%b (rv0)", i,
                     rst_s, d0_s, d1_s,
                     exp_bit(rst_s, e.rst_n, 1'b0, e.d0),
                     exp_bit(rst_s, e.rst_n, 1'b0, e.d1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
